// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-organised data RAM behind valid/ready request and response
//            channels, with programmable wait states and error responses.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH       = 2 ** ADDR_W;
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              access_err;
    logic              do_access;
    logic              mem_wr;

    always_comb begin
        word_idx   = addr_q[ADDR_W+1:2];
        // Any set bit above the word index lies outside the RAM.
        access_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != 32'd0);
        do_access  = (state_q == BUSY) && (cnt_q == 4'd0);
        mem_wr     = do_access && we_q && !access_err;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = c_wait_init;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = access_err;
                    rdata_d = (!access_err && !we_q) ? mem[word_idx] : 32'd0;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    rdata_d = 32'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; an asynchronous reset forces IDLE, which blocks mem_wr.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && rst;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0 builds).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int ADDR_W = 10;
    localparam int W      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [3:0]  z_req_be;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_be(z_req_be), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] sb_q [$];
    logic [31:0] model [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: {err, rdata}; updates the memory model on good stores.
    function automatic logic [32:0] predict(input logic we, input logic [3:0] be,
                                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] cur;
        int          idx;
        if (addr[1:0] != 2'b00 || addr >= 32'(4 * (2 ** ADDR_W)))
            return {1'b1, 32'd0};
        idx = int'(addr >> 2);
        cur = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
            model[idx] = cur;
            return {1'b0, 32'd0};
        end
        return {1'b0, cur};
    endfunction

    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold,
                       output logic [31:0] rd, output logic er);
        int          k;
        logic [32:0] exp;
        logic [31:0] save_rd;
        logic        save_er;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        rsp_ready = !hold;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("accept_wait", 32'(k < 50), 32'd1);
        @(posedge clk);
        sb_q.push_back(predict(we, be, addr, wdata));
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("latency", 32'(k), 32'(W + 1));
        if (hold) begin
            save_rd   = rsp_rdata;
            save_er   = rsp_err;
            req_valid = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("bp_rdata", rsp_rdata, save_rd);
                chk("bp_err", {31'd0, rsp_err}, {31'd0, save_er});
                chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        exp = sb_q.pop_front();
        rd  = rsp_rdata;
        er  = rsp_err;
        chk("rsp_rdata", rsp_rdata, exp[31:0]);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp[32]});
        @(posedge clk); #1;
        chk("rsp_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_drop_rdata", rsp_rdata, 32'd0);
        chk("rsp_drop_err", {31'd0, rsp_err}, 32'd0);
        chk("ready_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          rdy [14];
        bit          vld [14];
        logic        errv [14];

        req_valid = 0; req_we = 0; req_be = 0; req_addr = 0; req_wdata = 0; rsp_ready = 1;
        z_req_valid = 0; z_req_we = 0; z_req_be = 0; z_req_addr = 0; z_req_wdata = 0; z_rsp_ready = 1;

        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Round trip
        txn(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er);
        txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("rt_load", rd, 32'hDEAD_BEEF);

        // Byte lanes
        txn(1'b1, 4'hF, 32'h20, 32'h1122_3344, 1'b0, rd, er);
        txn(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 1'b0, rd, er);
        txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, rd, er);
        chk("lane_load", rd, 32'h11BB_33DD);

        // Errors
        txn(1'b1, 4'hF, 32'h0, 32'h5A5A_0000, 1'b0, rd, er);
        txn(1'b1, 4'hF, 32'(4 * (2 ** ADDR_W)), 32'hFFFF_FFFF, 1'b0, rd, er);
        chk("oor_err", {31'd0, er}, 32'd1);
        txn(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, rd, er);
        chk("word0_kept", rd, 32'h5A5A_0000);
        txn(1'b0, 4'h0, 32'h22, 32'h0, 1'b0, rd, er);
        chk("misalign_err", {31'd0, er}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);

        // be=0000 store is a harmless no-op
        txn(1'b1, 4'h0, 32'h10, 32'h0BAD_0BAD, 1'b0, rd, er);
        chk("be0_err", {31'd0, er}, 32'd0);
        txn(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, rd, er);
        chk("be0_load", rd, 32'hDEAD_BEEF);

        // Backpressure
        txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b1, rd, er);
        chk("bp_load", rd, 32'h11BB_33DD);

        // Reset in BUSY aborts the store
        txn(1'b1, 4'hF, 32'h30, 32'h0102_0304, 1'b0, rd, er);
        req_we = 1'b1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_busy", {31'd0, req_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 4'h0, 32'h30, 32'h0, 1'b0, rd, er);
        chk("abort_old_data", rd, 32'h0102_0304);

        // Zero-wait build: back-to-back misaligned loads
        z_req_we = 1'b0; z_req_addr = 32'h2; z_req_valid = 1'b1; z_rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rdy[i]  = z_req_ready;
            vld[i]  = z_rsp_valid;
            errv[i] = z_rsp_err;
            @(posedge clk); #1;
        end
        z_req_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("w0_ready_%0d", i), {31'd0, rdy[i]}, {31'd0, (i % 3) == 0});
            chk($sformatf("w0_valid_%0d", i), {31'd0, vld[i]}, {31'd0, (i % 3) == 2});
            if ((i % 3) == 2)
                chk($sformatf("w0_err_%0d", i), {31'd0, errv[i]}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
